// File: rtl/parallel2serial_pkg.sv
// ============================================================================
// Module : p2s_defs (package)
// Brief  : State encodings and default word width shared by the serializer
//          and its matching deserializer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package p2s_defs;

    localparam int N_DEFAULT = 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

endpackage : p2s_defs

`default_nettype wire

// File: rtl/parallel2serial.sv
// ============================================================================
// Module : parallel2serial
// Brief  : Accepts an N-bit word on a load/ready handshake and shifts it out
//          LSB first, one bit per clock, with serial_start on bit 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parallel2serial
    import p2s_defs::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         load,
    output logic         ready,
    output logic         serial_start,
    output logic         d,
    output logic         busy,
    output logic         done
);

    localparam int             CW       = $clog2(N) + 1;
    localparam logic [CW-1:0]  C_LAST   = CW'(N - 1);
    localparam logic [CW-1:0]  C_PENULT = CW'(N - 2);

    logic [0:0]    r_state;
    logic [N-1:0]  r_shift;
    logic [CW-1:0] r_cnt;
    logic          r_d;
    logic          r_start;
    logic          r_busy;
    logic          r_done;

    logic          w_last;
    logic          w_ready;
    logic          w_accept;

    // The last-bit cycle also accepts, which gives the zero-gap word stream.
    assign w_last   = (r_state == SHIFT) && (r_cnt == C_LAST);
    assign w_ready  = (r_state == IDLE) || w_last;
    assign w_accept = load && w_ready;

    assign ready        = w_ready && !reset;
    assign serial_start = r_start;
    assign d            = r_d;
    assign busy         = r_busy;
    assign done         = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_d     <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_accept) begin
            // Bit 0 goes straight to d; the register holds the bits still to come.
            r_state <= SHIFT;
            r_shift <= {1'b0, data_in[N-1:1]};
            r_cnt   <= '0;
            r_d     <= data_in[0];
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_last) begin
                r_state <= IDLE;
                r_shift <= '0;
                r_cnt   <= '0;
                r_d     <= 1'b0;
                r_start <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt + CW'(1);
                r_d     <= r_shift[0];
                r_start <= 1'b0;
                r_done  <= (r_cnt == C_PENULT);
            end
        end
    end

endmodule : parallel2serial

`default_nettype wire

// File: tb/tb_parallel2serial.sv
// ============================================================================
// Module : tb_parallel2serial
// Brief  : Scoreboard bench for parallel2serial (N=8 random plus N=4 directed).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parallel2serial;

    typedef struct packed {
        logic start;
        logic d;
        logic busy;
        logic done;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic       ready, serial_start, d, busy, done;

    logic       reset4;
    logic       load4;
    logic [3:0] data4;
    logic       ready4, start4, d4, busy4, done4;

    int   n_pass  = 0;
    int   n_total = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    parallel2serial #(.N(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .load         (load),
        .ready        (ready),
        .serial_start (serial_start),
        .d            (d),
        .busy         (busy),
        .done         (done)
    );

    parallel2serial #(.N(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset4),
        .data_in      (data4),
        .load         (load4),
        .ready        (ready4),
        .serial_start (start4),
        .d            (d4),
        .busy         (busy4),
        .done         (done4)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    endtask

    // Reference model: an accepted word becomes N future cycles of output,
    // and the block is ready whenever no future cycles are queued.
    task automatic drive(input bit rst, input bit ld, input logic [7:0] w);
        @(negedge clk);
        reset   = rst;
        load    = ld;
        data_in = w;
        if (rst) begin
            exp_q.delete();
        end else if (ld && exp_q.size() == 0) begin
            for (int k = 0; k < 8; k++)
                exp_q.push_back('{start: (k == 0), d: w[k], busy: 1'b1, done: (k == 7)});
        end
    endtask

    // Monitor: one expected record per cycle, idle when nothing is queued.
    initial begin
        out_t exp_o;
        out_t act_o;
        forever begin
            @(posedge clk);
            #1;
            exp_o = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            act_o = '{start: serial_start, d: d, busy: busy, done: done};
            check("outputs{start,d,busy,done}", {4'b0, act_o}, {4'b0, exp_o});
            check("ready", {7'b0, ready}, {7'b0, (!reset && exp_q.size() == 0)});
        end
    end

    initial begin
        logic [3:0] w4;
        reset   = 1'b1;
        load    = 1'b0;
        data_in = '0;
        reset4  = 1'b1;
        load4   = 1'b0;
        data4   = '0;

        repeat (3) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        // Single word
        drive(1'b0, 1'b1, 8'hA5);
        repeat (10) drive(1'b0, 1'b0, 8'($urandom));

        // Back-to-back, second word offered in the last-bit cycle
        drive(1'b0, 1'b1, 8'h3C);
        repeat (7) drive(1'b0, 1'b0, 8'($urandom));
        drive(1'b0, 1'b1, 8'hC3);
        repeat (10) drive(1'b0, 1'b0, 8'($urandom));

        // Load while busy at bit index 3
        drive(1'b0, 1'b1, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'hFF);
        repeat (6) drive(1'b0, 1'b0, 8'hFF);

        // Reset at bit index 4, then a fresh word
        drive(1'b0, 1'b1, 8'hF0);
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h81);
        repeat (10) drive(1'b0, 1'b0, 8'h00);

        // Random traffic with occasional resets
        repeat (2000)
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 8'($urandom));
        repeat (12) drive(1'b0, 1'b0, 8'h00);

        // N = 4 instance: 4'b1011 -> d = 1,1,0,1
        @(negedge clk);
        reset4 = 1'b0;
        @(negedge clk);
        load4 = 1'b1;
        data4 = 4'b1011;
        w4    = 4'b1011;
        @(negedge clk);
        load4 = 1'b0;
        data4 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("n4{start,d,done,ready}", {4'b0, start4, d4, done4, ready4},
                  {4'b0, (i == 0), w4[i], (i == 3), (i == 3)});
        end
        @(negedge clk);
        check("n4 idle{busy,d}", {6'b0, busy4, d4}, 8'h00);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_parallel2serial

`default_nettype wire
